// File: rtl/mul_share_pkg.sv
// mul_share_pkg: shared types, sizing and round-robin helper for the shared multiplier block.
// Revision 1.0
`default_nettype none

package mul_share_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int PW        = 2 * WIDTH_DEF;
  localparam int CYC       = 2 * WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid, scanning from ptr upward and wrapping at n (n <= 8).
  function automatic rr_pick_t rr_find(input logic [7:0] valid, input logic [2:0] ptr,
                                       input int n);
    rr_pick_t r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (int'(ptr) + k) % n;
      if (k < n && !r.found && valid[j]) begin
        r.found = 1'b1;
        r.idx   = 3'(j);
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_seq_core.sv
// mul_seq_core: signed shift-add multiplier, one multiplier bit per clock over 2*WIDTH clocks.
// Revision 1.0
`default_nettype none

module mul_seq_core
  import mul_share_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int PWL = 2 * WIDTH;
  localparam int CW  = $clog2(PWL) + 1;

  logic [PWL-1:0] mcand_q, mplier_q, acc_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q, done_q;

  // Sign-extending both operands to 2*WIDTH makes the modulo sum the exact signed product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        mcand_q  <= {{WIDTH{a_i[WIDTH-1]}}, a_i};
        mplier_q <= {{WIDTH{b_i[WIDTH-1]}}, b_i};
        acc_q    <= '0;
        cnt_q    <= '0;
        run_q    <= 1'b1;
      end else if (run_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
        if (cnt_q == CW'(PWL - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign p_o    = acc_q;

endmodule

`default_nettype wire

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one sequential multiplier among NREQ requesters.
// Revision 1.0
`default_nettype none

module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [IDW-1:0]        resp_id_o,
  output logic [2*WIDTH-1:0]    resp_p_o,
  output logic                  busy_o
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, id_q, resp_id_q;
  logic                 resp_valid_q;
  logic [2*WIDTH-1:0]   resp_p_q, core_p;
  logic                 core_done, accept;
  logic [WIDTH-1:0]     a_sel, b_sel;
  rr_pick_t             pick;

  always_comb begin
    pick   = rr_find(8'(req_valid_i), 3'(rr_ptr_q), NREQ);
    accept = (state_q == IDLE) && pick.found && !reset;
    a_sel  = req_a_i[int'(pick.idx)*WIDTH +: WIDTH];
    b_sel  = req_b_i[int'(pick.idx)*WIDTH +: WIDTH];
  end

  assign req_ready_o = accept ? (NREQ'(1) << pick.idx) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (core_done) state_d = RESP;
      RESP:    if (resp_valid_q && resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_p_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q     <= IDW'(pick.idx);
        rr_ptr_q <= (int'(pick.idx) == NREQ - 1) ? '0 : IDW'(pick.idx + 3'd1);
      end
      // Response fields are only rewritten on completion, so they persist after the handshake.
      if (state_q == BUSY && core_done) begin
        resp_valid_q <= 1'b1;
        resp_id_q    <= id_q;
        resp_p_q     <= core_p;
      end else if (resp_valid_q && resp_ready_i) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  mul_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .start_i (accept),
    .a_i     (a_sel),
    .b_i     (b_sel),
    .done_o  (core_done),
    .p_o     (core_p)
  );

  assign resp_valid_o = resp_valid_q;
  assign resp_id_o    = resp_id_q;
  assign resp_p_o     = resp_p_q;
  assign busy_o       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed stimulus with a queued scoreboard for mul_share_arbiter.
// Revision 1.0
`default_nettype none

module tb_mul_share_arbiter;

  logic        clk, reset;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_id;
  logic [15:0] resp_p;
  logic        busy;

  mul_share_arbiter #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_p_o     (resp_p),
    .busy_o       (busy)
  );

  typedef struct {
    logic [1:0]  id;
    logic [15:0] p;
  } exp_t;

  exp_t        sb_q[$];
  int          lat_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  logic [7:0]  ta[4], tb[4];
  logic [15:0] tp[4];
  logic        prev_valid, prev_ready;
  logic [1:0]  prev_id;
  logic [15:0] prev_p;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail_chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, got, exp);
    end
  endtask

  // Monitor: protocol checks and scoreboard comparison, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
    end else begin
      if (busy) fail_chk("ready_when_busy", {28'd0, req_ready}, 32'd0);
      else      fail_chk("ready_onehot", ($countones(req_ready) <= 1), 32'd1);
      if (prev_valid && !prev_ready) begin
        fail_chk("hold_valid", resp_valid, 32'd1);
        fail_chk("hold_id", resp_id, prev_id);
        fail_chk("hold_p", resp_p, prev_p);
      end
      if (resp_valid && !prev_valid) begin
        if (lat_q.size() == 0) fail_chk("latency_unexpected", 32'd1, 32'd0);
        else fail_chk("latency", cyc - lat_q.pop_front() - 1, 32'd17);
      end
      if (resp_valid && resp_ready) begin
        if (sb_q.size() == 0) begin
          fail_chk("unexpected_resp", {30'd0, resp_id}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          fail_chk("resp_id", resp_id, e.id);
          fail_chk("resp_p", resp_p, e.p);
        end
      end
      prev_valid = resp_valid;
      prev_ready = resp_ready;
      prev_id    = resp_id;
      prev_p     = resp_p;
    end
  end

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_a[8*i +: 8] = ta[i];
      req_b[8*i +: 8] = tb[i];
    end
  endtask

  task automatic wait_grant(output int gid);
    gid = -1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (req_ready != 4'd0) begin
        for (int i = 0; i < 4; i++) if (req_ready[i]) gid = i;
        lat_q.push_back(cyc);
        return;
      end
    end
    fail_chk("grant_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 600; t++) begin
      if (sb_q.size() == 0 && !resp_valid) begin
        @(posedge clk); #2;
        return;
      end
      @(negedge clk);
    end
    fail_chk("drain_timeout", sb_q.size(), 32'd0);
    @(posedge clk); #2;
  endtask

  // order[2k+1:2k] is the k-th expected winner; all masked requesters hold valid throughout.
  task automatic run_group(input logic [3:0] mask, input int n, input logic [15:0] order);
    int g;
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.id = order[2*k +: 2];
      e.p  = tp[order[2*k +: 2]];
      sb_q.push_back(e);
    end
    load_ops();
    req_valid = mask;
    for (int k = 0; k < n; k++) begin
      wait_grant(g);
      fail_chk("grant_order", g, {30'd0, order[2*k +: 2]});
      @(posedge clk); #2;
      if (g < 0) break;
    end
    req_valid = 4'd0;
    drain();
  endtask

  task automatic check_zero_outputs(input string tag);
    fail_chk({tag, "_resp_valid"}, resp_valid, 32'd0);
    fail_chk({tag, "_resp_id"}, resp_id, 32'd0);
    fail_chk({tag, "_resp_p"}, resp_p, 32'd0);
    fail_chk({tag, "_busy"}, busy, 32'd0);
    fail_chk({tag, "_req_ready"}, req_ready, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int g;
    exp_t e;
    reset = 1'b1; req_valid = 4'd0; req_a = '0; req_b = '0; resp_ready = 1'b1;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_id = '0; prev_p = '0;
    ta[0] = 8'd2;  tb[0] = 8'd3;  tp[0] = 16'h0006;
    ta[1] = 8'hFF; tb[1] = 8'hFF; tp[1] = 16'h0001;
    ta[2] = 8'h0A; tb[2] = 8'hF6; tp[2] = 16'hFF9C;
    ta[3] = 8'h80; tb[3] = 8'h7F; tp[3] = 16'hC080;
    repeat (3) @(posedge clk);
    #2;
    check_zero_outputs("reset");
    reset = 1'b0;
    @(posedge clk); #2;

    run_group(4'b1111, 5, 16'h00E4);

    ta[0] = 8'd3;  tb[0] = 8'd5;  tp[0] = 16'h000F; run_group(4'b0001, 1, 16'h0000);
    ta[0] = 8'hFD; tb[0] = 8'd5;  tp[0] = 16'hFFF1; run_group(4'b0001, 1, 16'h0000);
    ta[0] = 8'h80; tb[0] = 8'h80; tp[0] = 16'h4000; run_group(4'b0001, 1, 16'h0000);
    ta[0] = 8'h7F; tb[0] = 8'hFF; tp[0] = 16'hFF81; run_group(4'b0001, 1, 16'h0000);

    // Requester 1 leaves the pointer at 2, so 3 must win over 1, then the pointer returns to 2.
    ta[0] = 8'd2; tb[0] = 8'd3; tp[0] = 16'h0006;
    run_group(4'b0010, 1, 16'h0001);
    run_group(4'b1010, 2, 16'h0007);
    run_group(4'b0111, 3, 16'h0012);

    ta[1] = 8'hF9; tb[1] = 8'h09; tp[1] = 16'hFFC1;
    ta[2] = 8'h04; tb[2] = 8'hFC; tp[2] = 16'hFFF0;
    load_ops();
    e.id = 2'd1; e.p = tp[1]; sb_q.push_back(e);
    e.id = 2'd2; e.p = tp[2]; sb_q.push_back(e);
    resp_ready = 1'b0;
    req_valid  = 4'b0010;
    wait_grant(g);
    fail_chk("bp_grant", g, 32'd1);
    @(posedge clk); #2;
    req_valid = 4'b0100;
    for (int t = 0; t < 40 && !resp_valid; t++) @(negedge clk);
    fail_chk("bp_resp_seen", resp_valid, 32'd1);
    repeat (10) @(negedge clk);
    @(posedge clk); #2;
    resp_ready = 1'b1;
    @(negedge clk);
    fail_chk("bp_no_grant_at_handshake", req_ready, 32'd0);
    @(negedge clk);
    fail_chk("bp_grant_after_handshake", req_ready, 32'h4);
    if (req_ready == 4'b0100) lat_q.push_back(cyc);
    @(posedge clk); #2;
    req_valid = 4'd0;
    drain();

    ta[3] = 8'd5; tb[3] = 8'd5;
    load_ops();
    req_valid = 4'b1000;
    wait_grant(g);
    fail_chk("abort_grant", g, 32'd3);
    if (lat_q.size() > 0) void'(lat_q.pop_back());
    @(posedge clk); #2;
    req_valid = 4'd0;
    repeat (4) @(posedge clk);
    #2;
    fail_chk("abort_busy_before", busy, 32'd1);
    reset = 1'b1;
    #1;
    check_zero_outputs("midop");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk); #2;
    ta[2] = 8'hFB; tb[2] = 8'h06; tp[2] = 16'hFFE2;
    run_group(4'b0100, 1, 16'h0002);
    repeat (30) @(negedge clk);
    fail_chk("no_stray_resp", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one signed iterative shift-add multiplier core between NREQ requesters.
- Round-robin arbitration, valid/ready request handshake per requester, single tagged response channel with backpressure.
- Sits between requesting datapath units and the multiplier core; owns core sequencing, start, and result capture.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width; product is 2*WIDTH bits.
- IDW, 2, requester-ID width; must equal clog2(NREQ).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  NREQ*WIDTH  packed signed multiplicands; slice i belongs to requester i.
- req_b  input  NREQ*WIDTH  packed signed multipliers.
- resp_valid  output  1  product valid.
- resp_ready  input  1  consumer accepts product.
- resp_id  output  IDW  requester index of the current product.
- resp_p  output  2*WIDTH  signed product, two's complement.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-high, clock clk. On reset: state=IDLE, rr_ptr=0, resp_valid=0, resp_id=0, resp_p=0, busy=0, req_ready=0, and the core is cleared.
- Reset mid-operation aborts the in-flight multiply. No response is produced for the aborted request.
- States:
  - IDLE to BUSY on any request handshake.
  - BUSY to RESP when core done.
  - RESP to IDLE on resp_valid & resp_ready.
- Arbitration in IDLE only:
  - Winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[winner]=1 combinationally in that cycle. Handshake is req_valid & req_ready.
  - req_ready is 0 in BUSY and RESP.
- On the accept edge:
  - Capture a, b, and winner ID.
  - Pulse core start.
  - Set rr_ptr = (winner+1) mod NREQ. This includes the wrap from NREQ-1 to 0.
- Core:
  - Operands are sign-extended to 2*WIDTH bits.
  - One multiplier bit is examined per cycle for 2*WIDTH cycles. Partial sum adds the left-shifted multiplicand when the bit is 1.
  - Result is modulo 2^(2*WIDTH), i.e. an exact signed product.
- Latency: resp_valid rises exactly 2*WIDTH+1 clocks after the accept edge (17 for WIDTH=8).
- RESP hold rules:
  - resp_valid, resp_id, and resp_p are registered and held stable until resp_ready=1.
  - resp_p and resp_id retain their last values after the handshake; resp_valid drops.
- Throughput: at most one request per 2*WIDTH+3 cycles. IDLE lasts at least one cycle after each response handshake.
- Requester inputs are ignored outside IDLE. A requester may drop req_valid before acceptance without effect.
- If resp_ready is already high on entry to RESP, the response completes in one cycle.
- Operand edge case -2^(WIDTH-1) × -2^(WIDTH-1) yields +2^(2*WIDTH-2). No overflow occurs.

Decomposition:
- Shared package mul_share_pkg holds:
  - state enum: IDLE, BUSY, RESP.
  - localparams PW=2*WIDTH and CYC=2*WIDTH.
  - round-robin find-first function.
- One sub-module: mul_seq_core (start/done interface, signed sequential shift-add, 5-bit counter for WIDTH=8), instantiated once.

Test Plan:
- Single request: req 0 with a=3, b=5 -> resp_valid after 17 cycles, resp_id=0, resp_p=0x000F.
- Signed cases:
  - a=-3 (0xFD), b=5 -> resp_p=0xFFF1.
  - a=-128, b=-128 -> resp_p=0x4000.
  - a=127, b=-1 -> resp_p=0xFF81.
- Contention: all four req_valid held high from reset, resp_ready=1 -> grants in order 0,1,2,3,0. Exactly one req_ready high per IDLE cycle, none in BUSY/RESP.
- Wrap-around fairness: requesters 3 and 1 valid with rr_ptr=2 -> 3 served first, then 1, then rr_ptr=2.
- Backpressure: resp_ready low for 10 cycles in RESP -> resp_valid/resp_id/resp_p stable. New req_valid is not accepted until one cycle after the response handshake.
- Reset mid-op: assert reset 5 cycles after accept -> all outputs 0 immediately. No response for the aborted request. A post-reset request from requester 2 is granted first and returns a correct product.
